// File: rtl/scm_pkg.sv
// Shared types for the SCM burst reader: FSM state encoding and FIFO sizing.
package scm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } scm_reader_state_e;

  localparam int unsigned FifoEntries = 2;

endpackage

// File: rtl/scm_reader_fifo.sv
// Two-entry output FIFO; entry 0 is always the head, so a stalled head never moves.
module scm_reader_fifo
  import scm_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic             clk_int,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [1:0]       count_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [FifoEntries];
  logic [Width-1:0] mem_d [FifoEntries];
  logic [1:0]       count_q, count_d;
  logic             push_ok_s, pop_ok_s, wr_idx_s;

  assign pop_ok_s  = pop_i && (count_q != 2'd0);
  assign push_ok_s = push_i && ((count_q != 2'd2) || pop_ok_s);
  // After a pop the slots shift down, so the free slot index drops by one.
  assign wr_idx_s  = pop_ok_s ? count_q[1] : count_q[0];

  // Next FIFO contents and occupancy.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop_ok_s) begin
      mem_d[0] = mem_q[1];
    end else begin
      mem_d[0] = mem_q[0];
    end
    if (push_ok_s) begin
      mem_d[wr_idx_s] = data_i;
    end else begin
      mem_d[wr_idx_s] = mem_d[wr_idx_s];
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= {Width{1'b0}};
      mem_q[1] <= {Width{1'b0}};
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];

endmodule

// File: rtl/scm_reader.sv
// Burst reader: walks SCM addresses from a base, wrapping at Depth, and streams
// the words out through a 2-entry FIFO with valid/ready flow control.
module scm_reader
  import scm_pkg::*;
#(
  parameter int unsigned C             = 32,
  parameter int unsigned K             = 16,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned AddrWidth     = $clog2(C*K),
  parameter int unsigned Depth         = C*K
) (
  input  logic                     clk_int,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AddrWidth-1:0]     base_addr_i,
  input  logic [AddrWidth:0]       len_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [AddrWidth-1:0]     raddr_o,
  input  logic [DataTypeWidth-1:0] rdata_i,
  output logic [DataTypeWidth-1:0] out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int unsigned RemW = AddrWidth + 1;

  scm_reader_state_e    state_q, state_d;
  logic [AddrWidth-1:0] raddr_q, raddr_d, raddr_inc_s;
  logic [RemW-1:0]      remaining_q, remaining_d;
  logic                 done_q, done_d;
  logic [1:0]           fifo_count_s;
  logic                 push_s, pop_s;

  assign pop_s  = (fifo_count_s != 2'd0) && out_ready_i;
  // A full FIFO can still accept a word in the same cycle its head leaves.
  assign push_s = (state_q == READ) && (remaining_q != {RemW{1'b0}}) &&
                  ((fifo_count_s != 2'd2) || pop_s);
  assign raddr_inc_s = (raddr_q == AddrWidth'(Depth - 1)) ? {AddrWidth{1'b0}}
                                                          : raddr_q + AddrWidth'(1);

  // Next-state, address and remaining-count logic.
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          raddr_d     = base_addr_i;
          remaining_d = len_i;
          state_d     = (len_i == {RemW{1'b0}}) ? DRAIN : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (push_s) begin
          raddr_d     = raddr_inc_s;
          remaining_d = remaining_q - RemW'(1);
          state_d     = (remaining_q == RemW'(1)) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (fifo_count_s == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      raddr_q     <= {AddrWidth{1'b0}};
      remaining_q <= {RemW{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  scm_reader_fifo #(
    .Width(DataTypeWidth)
  ) u_fifo (
    .clk_int(clk_int),
    .rst_ni (rst_ni),
    .push_i (push_s),
    .pop_i  (pop_s),
    .data_i (rdata_i),
    .count_o(fifo_count_s),
    .head_o (out_data_o)
  );

  assign out_valid_o = (fifo_count_s != 2'd0);
  assign busy_o      = (state_q != IDLE);
  assign raddr_o     = raddr_q;
  assign done_o      = done_q;

endmodule
